// File: rtl/snake_field_engine.sv
// rtl/snake_field_engine.sv - snake playfield renderer, apple placer, score and collision tracker
module snake_field_engine #(
  parameter int          MAX_LEN = 32,
  parameter int          GX_W    = 6,
  parameter int          GY_W    = 5,
  parameter int          GRID_W  = 40,
  parameter int          GRID_H  = 30,
  parameter int          SCORE_W = 8,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tick,
  input  logic [GX_W-1:0]                     grid_x,
  input  logic [GY_W-1:0]                     grid_y,
  input  logic                                blank,
  input  logic [MAX_LEN*(GX_W+GY_W)-1:0]      snake_bus,
  input  logic [$clog2(MAX_LEN+1)-1:0]        snake_len,
  output logic                                red,
  output logic                                green,
  output logic                                blue,
  output logic [GX_W-1:0]                     apple_x,
  output logic [GY_W-1:0]                     apple_y,
  output logic                                apple_valid,
  output logic                                eaten,
  output logic [SCORE_W-1:0]                  score,
  output logic                                collide
);
  localparam int SEG_W = GX_W + GY_W;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic {PLACE, ACTIVE} state_t;

  state_t              state, state_nxt;
  logic                load_apple, eat;
  logic [15:0]         lfsr;
  logic [LEN_W-1:0]    eff_len;
  logic [GX_W-1:0]     cand_x, head_x;
  logic [GY_W-1:0]     cand_y, head_y;
  logic [MAX_LEN-1:0]  seg_active, seg_pix, seg_cand, seg_head;
  logic                cand_ok, head_on_apple, head_hit, pix_wall;
  logic [2:0]          rgb_nxt;

  function automatic logic is_wall(input logic [GX_W-1:0] x, input logic [GY_W-1:0] y);
    return (x == '0) || (x == GX_W'(GRID_W - 1)) || (y == '0) || (y == GY_W'(GRID_H - 1));
  endfunction

  // Lengths beyond the bus capacity are treated as a full-length snake.
  assign eff_len = (snake_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : snake_len;

  assign cand_x = lfsr[GX_W-1:0];
  assign cand_y = lfsr[SEG_W-1:GX_W];
  assign head_x = snake_bus[GX_W-1:0];
  assign head_y = snake_bus[SEG_W-1:GX_W];

  // One comparator set per segment: against the pixel, the apple candidate and the head.
  for (genvar k = 0; k < MAX_LEN; k++) begin : g_seg
    logic [GX_W-1:0] sx;
    logic [GY_W-1:0] sy;
    assign sx            = snake_bus[k*SEG_W +: GX_W];
    assign sy            = snake_bus[k*SEG_W + GX_W +: GY_W];
    assign seg_active[k] = LEN_W'(k) < eff_len;
    assign seg_pix[k]    = seg_active[k] && (sx == grid_x) && (sy == grid_y);
    assign seg_cand[k]   = seg_active[k] && (sx == cand_x) && (sy == cand_y);
    assign seg_head[k]   = seg_active[k] && (sx == head_x) && (sy == head_y);
  end

  assign cand_ok = (cand_x >= GX_W'(1)) && (cand_x <= GX_W'(GRID_W - 2)) &&
                   (cand_y >= GY_W'(1)) && (cand_y <= GY_W'(GRID_H - 2)) && !(|seg_cand);
  assign head_on_apple = seg_active[0] && (head_x == apple_x) && (head_y == apple_y);
  assign head_hit      = seg_active[0] && (is_wall(head_x, head_y) || (|seg_head[MAX_LEN-1:1]));
  assign pix_wall      = is_wall(grid_x, grid_y);

  // Apple FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PLACE;
    else       state <= state_nxt;
  end

  // Apple FSM: hunt for a free interior cell, then wait for the head to reach it.
  always_comb begin
    state_nxt  = state;
    load_apple = 1'b0;
    eat        = 1'b0;
    case (state)
      PLACE: begin
        if (cand_ok) begin
          load_apple = 1'b1;
          state_nxt  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (head_on_apple) begin
          eat       = 1'b1;
          state_nxt = PLACE;
        end
      end
      default: state_nxt = PLACE;
    endcase
  end

  // Render priority: blank, wall, apple, head, body.
  always_comb begin
    rgb_nxt = 3'b000;
    if (blank)                                                            rgb_nxt = 3'b000;
    else if (pix_wall)                                                    rgb_nxt = 3'b001;
    else if (apple_valid && (grid_x == apple_x) && (grid_y == apple_y))   rgb_nxt = 3'b100;
    else if (seg_pix[0])                                                  rgb_nxt = 3'b010;
    else if (|seg_pix[MAX_LEN-1:1])                                       rgb_nxt = 3'b011;
  end

  // Free-running LFSR, apple/score bookkeeping, sticky collision and pixel register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr        <= SEED;
      apple_x     <= '0;
      apple_y     <= '0;
      apple_valid <= 1'b0;
      eaten       <= 1'b0;
      score       <= '0;
      collide     <= 1'b0;
      red         <= 1'b0;
      green       <= 1'b0;
      blue        <= 1'b0;
    end else begin
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      eaten <= eat;
      if (load_apple) begin
        apple_x     <= cand_x;
        apple_y     <= cand_y;
        apple_valid <= 1'b1;
      end
      if (eat) begin
        apple_valid <= 1'b0;
        if (score != '1) score <= score + 1'b1;
      end
      if (tick && !collide && head_hit) collide <= 1'b1;
      {red, green, blue} <= rgb_nxt;
    end
  end
endmodule

// File: tb/tb_snake_field_engine.sv
// tb/tb_snake_field_engine.sv - directed self-checking bench for snake_field_engine
module tb_snake_field_engine;
  localparam int MAX_LEN = 32;
  localparam int SEG_W   = 11;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       tick = 1'b0;
  logic [5:0]                 grid_x = '0;
  logic [4:0]                 grid_y = '0;
  logic                       blank = 1'b0;
  logic [MAX_LEN*SEG_W-1:0]   snake_bus = '0;
  logic [5:0]                 snake_len = '0;
  logic                       red, green, blue;
  logic [5:0]                 apple_x;
  logic [4:0]                 apple_y;
  logic                       apple_valid, eaten, collide;
  logic [7:0]                 score;

  int vectors = 0;
  int miscompares = 0;

  snake_field_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .grid_x(grid_x), .grid_y(grid_y),
    .blank(blank), .snake_bus(snake_bus), .snake_len(snake_len),
    .red(red), .green(green), .blue(blue), .apple_x(apple_x), .apple_y(apple_y),
    .apple_valid(apple_valid), .eaten(eaten), .score(score), .collide(collide)
  );

  always #5 clk = ~clk;

  task automatic set_seg(input int k, input int x, input int y);
    snake_bus[k*SEG_W +: SEG_W] = {5'(y), 6'(x)};
  endtask

  task automatic default_snake();
    snake_bus = '0;
    set_seg(0, 10, 10);
    set_seg(1, 9, 10);
    set_seg(2, 8, 10);
    snake_len = 6'd3;
  endtask

  function automatic bit on_snake(input int x, input int y);
    for (int k = 0; k < snake_len && k < MAX_LEN; k++)
      if (snake_bus[k*SEG_W +: 6] == 6'(x) && snake_bus[k*SEG_W + 6 +: 5] == 5'(y)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    tick = 1'b0; blank = 1'b0; grid_x = 6'd20; grid_y = 5'd20;
    default_snake();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic eat_apple();
    int n = 0;
    while (!apple_valid && n < 64) begin @(negedge clk); n++; end
    vectors++;
    if (!apple_valid) begin
      miscompares++;
      $display("FAIL apple_wait: apple_valid=%0b after %0d cycles, required 1", apple_valid, n);
    end else begin
      set_seg(0, apple_x, apple_y);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    default_snake();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({red, green, blue, apple_x, apple_y, apple_valid, eaten, score, collide} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rgb=%b apple=(%0d,%0d) v=%b eaten=%b score=%0d collide=%b, required all 0",
               {red, green, blue}, apple_x, apple_y, apple_valid, eaten, score, collide);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (apple_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_edge_apple: apple_valid=%b required 0", apple_valid);
    end
    @(negedge clk);
    vectors++;
    if (apple_valid !== 1'b1 || apple_x !== 6'd33 || apple_y !== 5'd19) begin
      miscompares++;
      $display("FAIL first_apple: v=%b (%0d,%0d), required v=1 (33,19)", apple_valid, apple_x, apple_y);
    end
  endtask

  task automatic test_render();
    int vx[10] = '{0, 33, 10, 9, 20, 8, 39, 5, 10, 33};
    int vy[10] = '{5, 19, 10, 10, 20, 10, 5, 29, 10, 19};
    bit vb[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [2:0] ex[10] = '{3'b001, 3'b100, 3'b010, 3'b011, 3'b000, 3'b011, 3'b001, 3'b001, 3'b000, 3'b000};
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if ({red, green, blue} !== ex[i-1]) begin
          miscompares++;
          $display("FAIL render_%0d (%0d,%0d,blank=%0b): rgb=%b required %b",
                   i-1, vx[i-1], vy[i-1], vb[i-1], {red, green, blue}, ex[i-1]);
        end
      end
      if (i < 10) begin
        grid_x = 6'(vx[i]); grid_y = 5'(vy[i]); blank = vb[i];
      end
    end
    blank = 1'b0;
    // length above capacity clamps to 32: segment 31 is drawn
    set_seg(31, 15, 15);
    snake_len = 6'd63;
    grid_x = 6'd15; grid_y = 5'd15;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({red, green, blue} !== 3'b011) begin
      miscompares++;
      $display("FAIL render_clamp: rgb=%b required 011", {red, green, blue});
    end
    snake_len = 6'd1;
    grid_x = 6'd9; grid_y = 5'd10;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({red, green, blue} !== 3'b000) begin
      miscompares++;
      $display("FAIL render_inactive: rgb=%b required 000", {red, green, blue});
    end
    snake_len = 6'd0;
    grid_x = 6'd10; grid_y = 5'd10;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({red, green, blue} !== 3'b000) begin
      miscompares++;
      $display("FAIL render_len0: rgb=%b required 000", {red, green, blue});
    end
    default_snake();
  endtask

  task automatic test_eat();
    int n = 0;
    eat_apple();
    vectors++;
    if (eaten !== 1'b1 || score !== 8'd1 || apple_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL eat_edge: eaten=%b score=%0d v=%b, required eaten=1 score=1 v=0", eaten, score, apple_valid);
    end
    @(negedge clk);
    vectors++;
    if (eaten !== 1'b0) begin
      miscompares++;
      $display("FAIL eat_pulse: eaten=%b required 0 one cycle later", eaten);
    end
    while (!apple_valid && n < 64) begin @(negedge clk); n++; end
    vectors++;
    if (apple_valid !== 1'b1 || apple_x < 1 || apple_x > 38 || apple_y < 1 || apple_y > 28 ||
        on_snake(apple_x, apple_y)) begin
      miscompares++;
      $display("FAIL new_apple: v=%b (%0d,%0d), required valid, inside 1..38x1..28, off snake",
               apple_valid, apple_x, apple_y);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300 && score != 8'd255; i++) eat_apple();
    vectors++;
    if (score !== 8'd255) begin
      miscompares++;
      $display("FAIL score_fill: score=%0d required 255", score);
    end
    eat_apple();
    vectors++;
    if (eaten !== 1'b1 || score !== 8'd255) begin
      miscompares++;
      $display("FAIL score_saturate: eaten=%b score=%0d, required eaten=1 score=255", eaten, score);
    end
  endtask

  task automatic test_reset_in_place();
    do_reset();
    repeat (5) eat_apple();
    vectors++;
    if (score !== 8'd5 || apple_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_abort: score=%0d v=%b, required score=5 v=0", score, apple_valid);
    end
    #1 reset = 1'b1;
    #1;
    vectors++;
    if (score !== 8'd0 || apple_valid !== 1'b0 || eaten !== 1'b0) begin
      miscompares++;
      $display("FAIL async_abort: score=%0d v=%b eaten=%b, required 0 0 0", score, apple_valid, eaten);
    end
    default_snake();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (apple_valid !== 1'b1 || apple_x !== 6'd33 || apple_y !== 5'd19) begin
      miscompares++;
      $display("FAIL restart_apple: v=%b (%0d,%0d), required v=1 (33,19)", apple_valid, apple_x, apple_y);
    end
  endtask

  task automatic test_collision();
    do_reset();
    set_seg(0, 0, 12);
    @(negedge clk);
    vectors++;
    if (collide !== 1'b0) begin
      miscompares++;
      $display("FAIL wall_no_tick: collide=%b required 0", collide);
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    vectors++;
    if (collide !== 1'b1) begin
      miscompares++;
      $display("FAIL wall_tick: collide=%b required 1", collide);
    end
    default_snake();
    tick = 1'b1;
    @(negedge clk); @(negedge clk);
    tick = 1'b0;
    vectors++;
    if (collide !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_sticky: collide=%b required 1", collide);
    end

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      snake_bus = '0;
      set_seg(0, 20, 5); set_seg(1, 21, 5); set_seg(2, 22, 5);
      set_seg(3, 22, 6); set_seg(4, 20, 5); set_seg(5, 19, 5);
      snake_len = (pass == 0) ? 6'd6 : 6'd4;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      vectors++;
      if (collide !== (pass == 0)) begin
        miscompares++;
        $display("FAIL self_hit_len%0d: collide=%b required %0b", snake_len, collide, pass == 0);
      end
    end

    do_reset();
    set_seg(0, 0, 12);
    snake_len = 6'd0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    vectors++;
    if (collide !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_tick: collide=%b required 0", collide);
    end
  endtask

  initial begin
    test_reset();
    test_render();
    test_eat();
    test_saturation();
    test_reset_in_place();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/snake_field_engine.md
# snake_field_engine

Parametrised playfield engine for the snake game. It renders a variable-length snake, the border walls and the apple into registered 1-bit RGB for the VGA pixel pipeline, and places the apple itself using an internal LFSR that rejects wall and body cells. It also detects eating, keeps a saturating score and latches head collisions. It sits between the snake movement logic, which drives the packed segment bus, and the VGA timing/output stage.

## Interface
Parameters:
- MAX_LEN, 32: maximum snake segments.
- GX_W, 6: grid x coordinate width.
- GY_W, 5: grid y coordinate width; GX_W+GY_W ≤ 16.
- GRID_W, 40: playfield width in cells, ≤ 2^GX_W.
- GRID_H, 30: playfield height in cells, ≤ 2^GY_W.
- SCORE_W, 8: score counter width.
- SEED, 16'hACE1: LFSR reset value, nonzero.

Ports:
- clk  in  1  pixel/system clock.
- reset  in  1  reset, asynchronous, active-high.
- tick  in  1  one-cycle pulse: snake has just moved; triggers collision check.
- grid_x  in  GX_W  cell x of current pixel.
- grid_y  in  GY_W  cell y of current pixel.
- blank  in  1  video blanking.
- snake_bus  in  MAX_LEN*(GX_W+GY_W)  segment k at bits [k*SEG_W +: SEG_W], SEG_W=GX_W+GY_W; x in low GX_W bits, y above; k=0 is the head.
- snake_len  in  clog2(MAX_LEN+1)  active segments; values above MAX_LEN clamp to MAX_LEN.
- red, green, blue  out  1 each  registered pixel colour.
- apple_x  out  GX_W  current apple x.
- apple_y  out  GY_W  current apple y.
- apple_valid  out  1  apple placed and displayed.
- eaten  out  1  one-cycle pulse per apple eaten.
- score  out  SCORE_W  apples eaten, saturating.
- collide  out  1  sticky collision flag.

## Operation
- Active segment: index k < min(snake_len, MAX_LEN). Inactive segments are ignored everywhere.
- Wall cell: x==0, x==GRID_W-1, y==0 or y==GRID_H-1.
- Render priority, evaluated per cycle:
  - blank → 000.
  - wall → blue 001.
  - apple_valid and pixel on apple → red 100.
  - pixel on active head (k=0) → green 010.
  - pixel on any active segment k≥1 → cyan 011.
  - otherwise → 000.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle with no gating.
  - Candidate: cx = lfsr[GX_W-1:0], cy = lfsr[GX_W+GY_W-1:GX_W].
  - Candidate valid iff 1 ≤ cx ≤ GRID_W-2, 1 ≤ cy ≤ GRID_H-2, and cx,cy matches no active segment.
- Apple FSM, states PLACE and ACTIVE:
  - PLACE: when the candidate is valid, load apple_x/apple_y, set apple_valid=1 and go to ACTIVE. Otherwise stay in PLACE and retry next cycle with the next LFSR value.
  - ACTIVE: when an active head equals the apple, pulse eaten, score += 1 (holds at 2^SCORE_W-1), clear apple_valid and go to PLACE.
- Collision: on tick with snake_len ≥ 1, set collide if the head is on a wall or equals any active segment k≥1. collide is sticky until reset. tick is ignored once collide=1.
- Eating and collision are independent; both may occur on the same cycle.
- snake_len=0: no snake pixels, no eating, no collision.

## Timing
- Reset values:
  - red/green/blue, apple_x, apple_y, apple_valid, eaten, score, collide = 0.
  - lfsr = SEED.
  - FSM = PLACE.
- Reset asserted mid-operation aborts placement and scoring immediately (asynchronous).
- Render latency: exactly 1 clk from grid_x/grid_y/blank to RGB.
- Placement: a valid candidate at edge N gives apple_valid=1 with the new coordinates after edge N. The first apple can appear 1 cycle after reset release.
- Eat at edge N:
  - eaten=1 and score incremented for the cycle after N.
  - apple_valid=0 after N.
  - Earliest new apple after edge N+1.
- collide is set after the edge that samples tick=1.
- Apple coordinates are stable while ACTIVE. snake_bus changes never move the apple.

## Test plan
- Reset with snake_len=3 at (10,10),(9,10),(8,10) → all outputs 0. Within ≤64 cycles apple_valid=1, with apple inside 1..38 × 1..28 and not on a snake cell.
- Head moved onto apple → eaten high for exactly 1 cycle, score 0→1, apple_valid low for ≥1 cycle, new apple valid and off-snake.
- Score at 255 (SCORE_W=8) and another apple eaten → score stays 255, eaten still pulses.
- Render sweep, blank=0:
  - (0,5) → 001; apple cell → 100; (10,10) → 010; (9,10) → 011; (20,20) → 000.
  - Each colour appears 1 cycle after its coordinates.
  - blank=1 → 000.
- Collision cases:
  - tick with head at (0,12) → collide=1 next cycle.
  - tick with head equal to segment 4 and snake_len=6 → collide=1.
  - Same overlap with snake_len=4 → collide stays 0.
- Assert reset while FSM is in PLACE with score=5 → score=0, apple_valid=0, lfsr=SEED. Placement restarts after release.
